peri_wb_bridge: RTL and testbench

Wishbone-slave to register-bus bridge sitting directly upstream of the peripheral top. Converts one classic Wishbone transfer into a single reg_cs/reg_ack transaction toward the peripheral reg bus, registers all request fields, and returns read data and acknowledge to the Wishbone master. An optional watchdog terminates transactions that the peripheral never acknowledges.

---
 rtl/peri_wb_bridge.sv | 172 +++++++++++++++++
 tb/tb_peri_wb_bridge.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/peri_wb_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : peri_wb_bridge                                             |
// | Description : Classic Wishbone slave to peripheral reg-bus bridge.       |
// |               Optional REQ watchdog: define PERI_BRIDGE_TIMEOUT_EN.      |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module peri_wb_bridge #(
    parameter int              AW       = 11,
    parameter int              DW       = 32,
    parameter int              TIMEOUT  = 255,
    parameter logic [DW-1:0]   ERR_DATA = 32'hDEAD_DEAD
) (
    input  logic              mclk,
    input  logic              s_reset_n,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [AW-1:0]     wbs_adr_i,
    input  logic [DW-1:0]     wbs_dat_i,
    input  logic [DW/8-1:0]   wbs_sel_i,
    output logic [DW-1:0]     wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              wbs_err_o,
    output logic              reg_cs,
    output logic              reg_wr,
    output logic [AW-1:0]     reg_addr,
    output logic [DW-1:0]     reg_wdata,
    output logic [DW/8-1:0]   reg_be,
    input  logic [DW-1:0]     reg_rdata,
    input  logic              reg_ack,
    output logic              timeout_flag
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("peri_wb_bridge: TIMEOUT must be at least 1");
    end

    logic [1:0]       r_state;
    logic             r_abort;
    logic             r_cs;
    logic             r_wr;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic [DW/8-1:0]  r_be;
    logic [DW-1:0]    r_dat_o;
    logic             r_ack_o;

    logic w_start;
    logic w_tc;
    logic w_abort_now;

    assign w_start     = wbs_cyc_i & wbs_stb_i;
    // A master that drops cyc on the very cycle the reg bus finishes still aborts.
    assign w_abort_now = r_abort | ~wbs_cyc_i;

`ifdef PERI_BRIDGE_TIMEOUT_EN
    localparam int              CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   c_tc = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;
    logic          r_err_o;
    logic          r_tflag;

    // Terminal count is the TIMEOUT-th REQ cycle without reg_ack.
    assign w_tc = (r_state == c_st_req) && (r_cnt == c_tc);

    always_ff @(posedge mclk) begin
        if (!s_reset_n) begin
            r_cnt   <= '0;
            r_err_o <= 1'b0;
            r_tflag <= 1'b0;
        end else begin
            r_err_o <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_cnt   <= '0;
                        r_tflag <= 1'b0;
                    end
                end
                c_st_req: begin
                    if (!reg_ack) begin
                        if (w_tc) begin
                            r_tflag <= 1'b1;
                            r_err_o <= ~w_abort_now;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wbs_err_o    = r_err_o;
    assign timeout_flag = r_tflag;
`else
    assign w_tc         = 1'b0;
    assign wbs_err_o    = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge mclk) begin
        if (!s_reset_n) begin
            r_state <= c_st_idle;
            r_abort <= 1'b0;
            r_cs    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_dat_o <= '0;
            r_ack_o <= 1'b0;
        end else begin
            r_ack_o <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_addr  <= wbs_adr_i;
                        r_wdata <= wbs_dat_i;
                        r_wr    <= wbs_we_i;
                        r_be    <= wbs_sel_i;
                        r_cs    <= 1'b1;
                        r_abort <= 1'b0;
                        r_state <= c_st_req;
                    end
                end
                c_st_req: begin
                    if (reg_ack || w_tc) begin
                        r_cs <= 1'b0;
                        if (w_abort_now) begin
                            r_state <= c_st_idle;
                        end else begin
                            r_state <= c_st_resp;
                            if (reg_ack) begin
                                r_ack_o <= 1'b1;
                                r_dat_o <= r_wr ? '0 : reg_rdata;
                            end else begin
                                r_dat_o <= ERR_DATA;
                            end
                        end
                    end else if (!wbs_cyc_i) begin
                        r_abort <= 1'b1;
                    end
                end
                c_st_resp: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cs    <= 1'b0;
                end
            endcase
        end
    end

    assign reg_cs    = r_cs;
    assign reg_wr    = r_wr;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_be    = r_be;
    assign wbs_dat_o = r_dat_o;
    assign wbs_ack_o = r_ack_o;

endmodule
`default_nettype wire

// File: tb/tb_peri_wb_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_peri_wb_bridge                                          |
// | Description : Directed self-checking bench for peri_wb_bridge.           |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_peri_wb_bridge;

    logic        mclk = 1'b0;
    logic        s_reset_n;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [10:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o, wbs_err_o;
    logic        reg_cs, reg_wr;
    logic [10:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        timeout_flag;

    int checks = 0;
    int errors = 0;

    peri_wb_bridge #(
        .AW(11), .DW(32), .TIMEOUT(8), .ERR_DATA(32'hDEAD_DEAD)
    ) u_dut (
        .mclk(mclk), .s_reset_n(s_reset_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_rdata(reg_rdata),
        .reg_ack(reg_ack), .timeout_flag(timeout_flag)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // Present a request and ack it on the (n+1)-th reg_cs-high cycle.
    task automatic xfer(input string tag, input logic we, input logic [10:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input int n,
                        input logic [31:0] rdata, input int exp_lat,
                        input logic [31:0] exp_dat);
        int lat;
        int csn;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        lat = 0;
        csn = 0;
        do begin
            tick();
            lat++;
            reg_ack = 1'b0;
            if (reg_cs) begin
                csn++;
                if (csn == 1) begin
                    check({tag, "_wr"},    reg_wr,    we);
                    check({tag, "_addr"},  reg_addr,  adr);
                    check({tag, "_wdata"}, reg_wdata, dat);
                    check({tag, "_be"},    reg_be,    sel);
                end
                if (csn == n + 1) begin
                    reg_ack   = 1'b1;
                    reg_rdata = rdata;
                end
            end
        end while (wbs_ack_o !== 1'b1 && lat < 40);
        reg_ack = 1'b0;
        check({tag, "_latency"},  lat,       exp_lat);
        check({tag, "_cs_cycles"}, csn,      n + 1);
        check({tag, "_dat_o"},    wbs_dat_o, exp_dat);
        check({tag, "_err"},      wbs_err_o, 0);
        check({tag, "_cs_low"},   reg_cs,    0);
    endtask

    task automatic end_xfer(input string tag);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        tick();
        check({tag, "_ack_pulse"}, wbs_ack_o, 0);
        check({tag, "_idle_cs"},   reg_cs,    0);
    endtask

    initial begin
        s_reset_n = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
        reg_rdata = '0; reg_ack = 1'b0;
        tick();
        tick();
        check("rst_cs",    reg_cs,       0);
        check("rst_ack",   wbs_ack_o,    0);
        check("rst_err",   wbs_err_o,    0);
        check("rst_dat",   wbs_dat_o,    0);
        check("rst_addr",  reg_addr,     0);
        check("rst_wdata", reg_wdata,    0);
        check("rst_be",    reg_be,       0);
        check("rst_wr",    reg_wr,       0);
        check("rst_tflag", timeout_flag, 0);
        s_reset_n = 1'b1;
        tick();

        // Write, ack 2 cycles after reg_cs: cs 3 cycles, ack 4 cycles after stb.
        xfer("wr", 1'b1, 11'h080, 32'h1234_5678, 4'hF, 2, 32'hFFFF_FFFF, 4, 32'h0);
        end_xfer("wr");

        // Read with ack in the first reg_cs cycle.
        xfer("rd", 1'b0, 11'h084, 32'h0, 4'hF, 0, 32'hA5A5_0001, 2, 32'hA5A5_0001);
        end_xfer("rd");

        // Back-to-back reads with stb held; second one sees RESP+IDLE gap.
        xfer("b2b0", 1'b0, 11'h088, 32'h0, 4'h3, 1, 32'h1111_0000, 3, 32'h1111_0000);
        xfer("b2b1", 1'b0, 11'h08C, 32'h0, 4'hC, 0, 32'h2222_0000, 3, 32'h2222_0000);
        end_xfer("b2b");

        // Master abort one cycle into REQ; peripheral acks in the 4th cs cycle.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 11'h090; wbs_sel_i = 4'hF;
        tick();
        check("abort_cs1", reg_cs, 1);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("abort_cs_hold", reg_cs, 1);
            check("abort_no_ack",  wbs_ack_o, 0);
            check("abort_no_err",  wbs_err_o, 0);
        end
        reg_ack = 1'b1; reg_rdata = 32'h5555_AAAA;
        tick();
        reg_ack = 1'b0;
        check("abort_cs_drop", reg_cs,    0);
        check("abort_no_ack2", wbs_ack_o, 0);
        check("abort_no_err2", wbs_err_o, 0);
        check("abort_dat_kept", wbs_dat_o, 32'h2222_0000);
        // Bridge must be back in IDLE already: next read has normal latency.
        xfer("post_abort", 1'b0, 11'h094, 32'h0, 4'hF, 0, 32'h0BAD_F00D, 2, 32'h0BAD_F00D);
        end_xfer("post_abort");

`ifdef PERI_BRIDGE_TIMEOUT_EN
        begin
            int lat;
            int csn;
            wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
            wbs_adr_i = 11'h0A0; wbs_sel_i = 4'hF;
            lat = 0; csn = 0;
            do begin
                tick();
                lat++;
                if (reg_cs) csn++;
                check("to_no_ack", wbs_ack_o, 0);
            end while (wbs_err_o !== 1'b1 && lat < 40);
            check("to_latency", lat, 9);
            check("to_cs_cycles", csn, 8);
            check("to_dat", wbs_dat_o, 32'hDEAD_DEAD);
            check("to_flag", timeout_flag, 1);
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            tick();
            check("to_err_pulse", wbs_err_o, 0);
            check("to_flag_sticky", timeout_flag, 1);
            // Ack on the terminal-count cycle: ack wins.
            xfer("to_ack_tc", 1'b0, 11'h0A4, 32'h0, 4'hF, 7, 32'h7777_8888, 9, 32'h7777_8888);
            check("to_flag_clr", timeout_flag, 0);
            end_xfer("to_ack_tc");
        end
`else
        check("no_to_flag", timeout_flag, 0);
`endif

        // Reset asserted for one cycle while in REQ.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 11'h0B0; wbs_dat_i = 32'hCAFE_BABE; wbs_sel_i = 4'h5;
        tick();
        check("mrst_cs_up", reg_cs, 1);
        s_reset_n = 1'b0;
        tick();
        check("mrst_cs",    reg_cs,    0);
        check("mrst_ack",   wbs_ack_o, 0);
        check("mrst_err",   wbs_err_o, 0);
        check("mrst_dat",   wbs_dat_o, 0);
        check("mrst_addr",  reg_addr,  0);
        check("mrst_wdata", reg_wdata, 0);
        check("mrst_be",    reg_be,    0);
        check("mrst_wr",    reg_wr,    0);
        s_reset_n = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        reg_ack = 1'b1;
        tick();
        reg_ack = 1'b0;
        check("mrst_ign_ack", wbs_ack_o, 0);
        check("mrst_idle_cs", reg_cs,    0);
        xfer("post_rst", 1'b0, 11'h0B4, 32'h0, 4'hF, 1, 32'h1357_9BDF, 3, 32'h1357_9BDF);
        end_xfer("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
